// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Purpose:
//   Consumer stage directly downstream of the SPI register file. It turns the
//   SPI-written enables and duty byte into NUM_CH registered chip outputs.
//   Each output is static low, static high, or a shared PWM waveform. The
//   block holds the prescaler, the 8-bit period counter, the optional duty
//   shadow register and the registered output drivers.
//
// Parameters:
//   PRESCALE : clk cycles per counter tick (1..65535). The PWM period is
//              256*PRESCALE clk cycles.
//   NUM_CH   : number of output channels.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   en_out       in   NUM_CH  per-channel output enable (has priority)
//   en_pwm       in   NUM_CH  per-channel PWM select
//   duty         in   8       shared duty cycle, 0x00 = 0 %, 0xFF = 100 %
//   out          out  NUM_CH  registered channel outputs
//   period_start out  1       one-clk pulse aligned with the first output
//                             value of each new period
//
// Configuration:
//   PWM_DUTY_SHADOW_EN
//     defined   : duty is captured into duty_q only on the tick that wraps
//                 the counter 255->0, so every period is glitch-free.
//     undefined : duty feeds the comparator directly; a new duty applies on
//                 the next clk and a runt pulse mid-period is possible.
//
// Handshake:
//   There is no valid/ready handshake. en_out, en_pwm and duty are
//   quasi-static register values that change only as whole-byte updates.
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13,
    parameter int unsigned NUM_CH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    input  logic [7:0]        duty,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic [15:0]       presc_q, presc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              period_start_q, period_start_d;
    logic              tick;
    logic              wrap;
    logic              pwm;
    logic [7:0]        duty_eff;

    // Prescaler and period counter next state.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        wrap    = tick && (cnt_q == 8'hFF);
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_q, duty_d;

    // The shadow loads on the wrapping tick. The comparator uses the
    // next-state value, so the first output of the new period already sees
    // the new duty.
    always_comb begin
        duty_d   = wrap ? duty : duty_q;
        duty_eff = duty_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= 8'd0;
        end else begin
            duty_q <= duty_d;
        end
    end
`else
    always_comb begin
        duty_eff = duty;
    end
`endif

    // The PWM is compared against the next counter value so that the
    // registered output lines up with the counter state after the edge.
    // 0xFF is forced to a constant high so that there is no one-count gap.
    always_comb begin
        pwm            = (duty_eff == 8'hFF) | (cnt_d < duty_eff);
        out_d          = en_out & (~en_pwm | {NUM_CH{pwm}});
        period_start_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q        <= 16'd0;
            cnt_q          <= 8'd0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule
